bf_sbox_writer: RTL

BF_SBOX_WRITER -- requirements
Module: bf_sbox_writer

---
 rtl/bf_sbox_writer.sv | 116 +++++++++++
 1 files changed

// File: rtl/bf_sbox_writer.sv
// Blowfish-style S-box table: streamed full-table loader with a pipelined,
// registered lookup port that only hits once all 256 entries are written.
module bf_sbox_writer #(
  parameter int DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              load_done,
  output logic              busy,
  input  logic              lookup_valid,
  input  logic [7:0]        lookup_idx,
  output logic [DATA_W-1:0] lookup_data,
  output logic              lookup_rvalid,
  output logic              lookup_miss
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    LOADED  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        ptr_q;
  logic              wr_fire;
  logic              lookup_hit;
  logic [DATA_W-1:0] mem [256];

  // load_start aborts any handshake landing in the same cycle.
  assign wr_fire    = wr_valid && wr_ready && !load_start;
  assign lookup_hit = (state_q == LOADED);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = LOADING;
    end else if (state_q == LOADING && wr_fire && ptr_q == 8'hFF) begin
      state_d = LOADED;
    end
  end

  always_comb begin
    wr_ready = (state_q == LOADING);
  end

  // The pointer wraps to 0 after the last entry and is then idle until the
  // next load_start, since wr_ready is low outside LOADING.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ptr_q <= 8'd0;
    end else if (load_start) begin
      ptr_q <= 8'd0;
    end else if (wr_fire) begin
      ptr_q <= ptr_q + 8'd1;
    end
  end

  // NOTE: the table array has no reset; clearing 256 entries is not wanted
  // (contents survive reset) and a reset would block RAM inference.
  always_ff @(posedge wb_clk_i) begin
    if (wr_fire && !wb_rst_i) begin
      mem[ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      busy      <= (state_q == LOADING);
      load_done <= (state_q == LOADED);
    end
  end

  // Hit/miss is decided by the state on the request cycle, so a lookup that
  // coincides with a restart from LOADED still returns table data.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lookup_rvalid <= 1'b0;
      lookup_miss   <= 1'b0;
      lookup_data   <= '0;
    end else begin
      lookup_rvalid <= lookup_valid;
      if (lookup_valid) begin
        if (lookup_hit) begin
          lookup_data <= mem[lookup_idx];
          lookup_miss <= 1'b0;
        end else begin
          lookup_data <= '0;
          lookup_miss <= 1'b1;
        end
      end else begin
        lookup_miss <= 1'b0;
      end
    end
  end

endmodule
